// File: rtl/l2_bank_pkg.sv
// rtl/l2_bank_pkg.sv - shared types and constants for the L2 bank initiator
package l2_bank_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } init_state_e;

    localparam int unsigned RESP_DEPTH = 2;

    typedef struct packed {
        logic        is_write;
        logic [31:0] rdata;
    } resp_t;

    // Write responses carry no data back to the master
    function automatic logic [31:0] resp_data(input resp_t r);
        return r.is_write ? 32'h0 : r.rdata;
    endfunction

endpackage

// File: rtl/l2_resp_fifo.sv
// rtl/l2_resp_fifo.sv - 2-entry registered response FIFO, head read straight from storage
module l2_resp_fifo
    import l2_bank_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  resp_t      data_i,
    input  logic       pop_i,
    output resp_t      data_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [1:0] occ_o
);

    resp_t      mem_q [RESP_DEPTH];
    resp_t      mem_d [RESP_DEPTH];
    logic       wptr_q, wptr_d;
    logic       rptr_q, rptr_d;
    logic [1:0] occ_q, occ_d;
    logic       do_push;
    logic       do_pop;

    // Pointer/occupancy update; a push into a full FIFO is only taken alongside a pop,
    // in which case it lands in the slot being vacated this cycle
    always_comb begin
        do_pop  = pop_i & (occ_q != 2'd0);
        do_push = push_i & ((occ_q != 2'd2) | do_pop);
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (do_push) begin
            mem_d[wptr_q] = data_i;
            wptr_d        = ~wptr_q;
        end
        if (do_pop) begin
            rptr_d = ~rptr_q;
        end
        occ_d = occ_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    // Storage and pointer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q  <= '{default: '0};
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            occ_q  <= 2'd0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

    assign data_o  = mem_q[rptr_q];
    assign full_o  = (occ_q == 2'd2);
    assign empty_o = (occ_q == 2'd0);
    assign occ_o   = occ_q;

endmodule

// File: rtl/l2_bank_initiator.sv
// rtl/l2_bank_initiator.sv - req/gnt master port to SRAM bank port bridge; L2_BANK_INIT_CLEAR_EN adds a zeroing sweep after reset
module l2_bank_initiator
    import l2_bank_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned NB_BANKS   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [31:0]           add_i,
    input  logic                  wen_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [31:0]           r_rdata_o,
    output logic                  init_done_o,
    output logic                  mem_csn_o,
    output logic                  mem_wen_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i
);

    // Byte offset plus bank-select bits sit below the bank word address
    localparam int unsigned ADDR_LSB = 2 + $clog2(NB_BANKS);

    init_state_e state_q, state_d;
    logic        inflight_q, inflight_d;
    logic        inflight_write_q, inflight_write_d;

`ifdef L2_BANK_INIT_CLEAR_EN
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
`endif

    resp_t                 push_data;
    resp_t                 head;
    logic                  fifo_empty;
    logic [1:0]            fifo_occ;
    logic                  pop;
    logic [2:0]            load;
    logic                  grant_ok;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  unused_add;
    logic                  unused_full;

    assign req_addr   = add_i[ADDR_LSB +: ADDR_WIDTH];
    assign unused_add = ^add_i;

    // Responses are popped only when the master takes them
    assign pop = r_valid_o & r_ready_i;

    // Outstanding work after this cycle's pop; a new grant must keep it within the FIFO depth
    assign load     = {1'b0, fifo_occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign grant_ok = (state_q == RUN) & (load < 3'd2);

    // Bank data is valid in the cycle after the grant; writes return zero
    assign push_data = '{is_write: inflight_write_q,
                         rdata:    (inflight_write_q ? 32'h0 : mem_rdata_i)};

    l2_resp_fifo u_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (inflight_q),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (unused_full),
        .empty_o (fifo_empty),
        .occ_o   (fifo_occ)
    );

    assign r_valid_o   = ~fifo_empty;
    assign r_rdata_o   = r_valid_o ? resp_data(head) : 32'h0;
    assign init_done_o = (state_q == RUN);

    // State, sweep counter and inflight registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= INIT;
            inflight_q       <= 1'b0;
            inflight_write_q <= 1'b0;
`ifdef L2_BANK_INIT_CLEAR_EN
            cnt_q            <= '0;
`endif
        end else begin
            state_q          <= state_d;
            inflight_q       <= inflight_d;
            inflight_write_q <= inflight_write_d;
`ifdef L2_BANK_INIT_CLEAR_EN
            cnt_q            <= cnt_d;
`endif
        end
    end

    // Next state: INIT ends after one cycle, or after the last sweep address when clearing
    always_comb begin
        state_d = state_q;
`ifdef L2_BANK_INIT_CLEAR_EN
        cnt_d = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (&cnt_q) begin
                state_d = RUN;
            end
        end
`else
        if (state_q == INIT) begin
            state_d = RUN;
        end
`endif
    end

    // A grant marks the next cycle as carrying a bank response, remembering read/write
    always_comb begin
        inflight_d       = gnt_o;
        inflight_write_d = gnt_o & ~wen_i;
    end

    // Bank port and grant: forward a granted request, otherwise idle (or sweep in INIT)
    always_comb begin
        gnt_o       = 1'b0;
        mem_csn_o   = 1'b1;
        mem_wen_o   = 1'b1;
        mem_be_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = 32'h0;
        if (state_q == RUN) begin
            if (req_i && grant_ok) begin
                gnt_o       = 1'b1;
                mem_csn_o   = 1'b0;
                mem_wen_o   = wen_i;
                mem_be_o    = wen_i ? 4'hF : be_i;
                mem_addr_o  = req_addr;
                mem_wdata_o = wdata_i;
            end
        end
`ifdef L2_BANK_INIT_CLEAR_EN
        else if (rst_ni) begin
            mem_csn_o   = 1'b0;
            mem_wen_o   = 1'b0;
            mem_be_o    = 4'hF;
            mem_addr_o  = cnt_q;
            mem_wdata_o = 32'h0;
        end
`endif
    end

endmodule

// File: tb/tb_l2_bank_initiator.sv
// tb/tb_l2_bank_initiator.sv - directed self-checking bench for l2_bank_initiator
module tb_l2_bank_initiator;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] add_i;
    logic        wen_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        r_valid_o;
    logic        r_ready_i;
    logic [31:0] r_rdata_o;
    logic        init_done_o;
    logic        mem_csn_o;
    logic        mem_wen_o;
    logic [3:0]  mem_be_o;
    logic [11:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    logic [31:0] bank [4096];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    l2_bank_initiator #(
        .ADDR_WIDTH (12),
        .NB_BANKS   (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .add_i       (add_i),
        .wen_i       (wen_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .r_valid_o   (r_valid_o),
        .r_ready_i   (r_ready_i),
        .r_rdata_o   (r_rdata_o),
        .init_done_o (init_done_o),
        .mem_csn_o   (mem_csn_o),
        .mem_wen_o   (mem_wen_o),
        .mem_be_o    (mem_be_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    // SRAM bank model: byte-masked writes, 1-cycle read latency
    always @(posedge clk) begin
        if (!mem_csn_o) begin
            if (!mem_wen_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be_o[b]) bank[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
                end
            end else begin
                mem_rdata_i <= bank[mem_addr_o];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic req, input logic [31:0] add, input logic wen,
                         input logic [3:0] be, input logic [31:0] wd);
        req_i   = req;
        add_i   = add;
        wen_i   = wen;
        be_i    = be;
        wdata_i = wd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_ni    = 1'b1;
        r_ready_i = 1'b1;
        drive(1'b1, 32'h10, 1'b0, 4'hF, 32'hDEADBEEF);
        #1 rst_ni = 1'b0;
        #1;
        chk("rst_gnt", gnt_o, 0);
        chk("rst_r_valid", r_valid_o, 0);
        chk("rst_r_rdata", r_rdata_o, 0);
        chk("rst_init_done", init_done_o, 0);
        chk("rst_csn", mem_csn_o, 1);
        chk("rst_wen", mem_wen_o, 1);
        chk("rst_be", mem_be_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_wdata", mem_wdata_o, 0);

        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        chk("init_done_before_edge", init_done_o, 0);
        chk("gnt_in_init", gnt_o, 0);

        // First RUN cycle: write word 1
        next_cycle(); #1;
        chk("init_done_run", init_done_o, 1);
        chk("wr_gnt", gnt_o, 1);
        chk("wr_csn", mem_csn_o, 0);
        chk("wr_wen", mem_wen_o, 0);
        chk("wr_be", mem_be_o, 4'hF);
        chk("wr_addr", mem_addr_o, 12'd1);
        chk("wr_wdata", mem_wdata_o, 32'hDEADBEEF);

        next_cycle(); drive(1'b1, 32'h10, 1'b1, 4'h0, 32'h0); #1;
        chk("rd_gnt", gnt_o, 1);
        chk("rd_wen", mem_wen_o, 1);
        chk("rd_be_forced", mem_be_o, 4'hF);
        chk("rd_addr", mem_addr_o, 12'd1);
        chk("wr_resp_not_yet", r_valid_o, 0);

        next_cycle(); drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h0); #1;
        chk("idle_gnt", gnt_o, 0);
        chk("idle_csn", mem_csn_o, 1);
        chk("wr_resp_valid", r_valid_o, 1);
        chk("wr_resp_data", r_rdata_o, 32'h0);

        next_cycle(); #1;
        chk("rd_resp_valid", r_valid_o, 1);
        chk("rd_resp_data", r_rdata_o, 32'hDEADBEEF);

        next_cycle(); #1;
        chk("resp_drained", r_valid_o, 0);

        // Partial write over DEADBEEF
        next_cycle(); drive(1'b1, 32'h10, 1'b0, 4'b0011, 32'h12345678); #1;
        chk("be_gnt", gnt_o, 1);
        chk("be_port", mem_be_o, 4'b0011);
        next_cycle(); drive(1'b1, 32'h10, 1'b1, 4'h0, 32'h0); #1;
        chk("be_rd_gnt", gnt_o, 1);
        next_cycle(); drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h0); #1;
        chk("be_wr_resp", r_rdata_o, 32'h0);
        next_cycle(); #1;
        chk("be_rd_valid", r_valid_o, 1);
        chk("be_rd_data", r_rdata_o, 32'hDEAD5678);
        next_cycle(); #1;
        chk("be_drained", r_valid_o, 0);

        // 16 back-to-back writes to words 32..47
        for (int k = 0; k < 18; k++) begin
            next_cycle();
            if (k < 16) drive(1'b1, (32 + k) << 4, 1'b0, 4'hF, 32'hA5000000 | k);
            else        drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h0);
            #1;
            if (k < 16) chk("b2b_wr_gnt", gnt_o, 1);
            if (k >= 2) begin
                chk("b2b_wr_valid", r_valid_o, 1);
                chk("b2b_wr_data", r_rdata_o, 32'h0);
            end
        end
        next_cycle(); #1;
        chk("b2b_wr_drained", r_valid_o, 0);

        // 16 back-to-back reads, responses in order with no bubbles
        for (int k = 0; k < 18; k++) begin
            next_cycle();
            if (k < 16) drive(1'b1, (32 + k) << 4, 1'b1, 4'h0, 32'h0);
            else        drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h0);
            #1;
            if (k < 16) chk("b2b_rd_gnt", gnt_o, 1);
            if (k >= 2) begin
                chk("b2b_rd_valid", r_valid_o, 1);
                chk("b2b_rd_data", r_rdata_o, 32'hA5000000 | (k - 2));
            end
        end
        next_cycle(); #1;
        chk("b2b_rd_drained", r_valid_o, 0);

        // Back-pressure: two grants then stall, outputs stable
        r_ready_i = 1'b0;
        next_cycle(); drive(1'b1, 32'd32 << 4, 1'b1, 4'h0, 32'h0); #1;
        chk("bp_gnt0", gnt_o, 1);
        next_cycle(); drive(1'b1, 32'd33 << 4, 1'b1, 4'h0, 32'h0); #1;
        chk("bp_gnt1", gnt_o, 1);
        chk("bp_valid_early", r_valid_o, 0);
        next_cycle(); drive(1'b1, 32'd34 << 4, 1'b1, 4'h0, 32'h0); #1;
        chk("bp_stall_gnt_a", gnt_o, 0);
        chk("bp_stall_csn_a", mem_csn_o, 1);
        chk("bp_stall_valid_a", r_valid_o, 1);
        chk("bp_stall_data_a", r_rdata_o, 32'hA5000000);
        for (int k = 0; k < 2; k++) begin
            next_cycle(); #1;
            chk("bp_stall_gnt", gnt_o, 0);
            chk("bp_stall_valid", r_valid_o, 1);
            chk("bp_stall_data", r_rdata_o, 32'hA5000000);
        end
        next_cycle(); r_ready_i = 1'b1; #1;
        chk("bp_resume_gnt", gnt_o, 1);
        chk("bp_drain0_valid", r_valid_o, 1);
        chk("bp_drain0_data", r_rdata_o, 32'hA5000000);
        next_cycle(); drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h0); #1;
        chk("bp_drain1_valid", r_valid_o, 1);
        chk("bp_drain1_data", r_rdata_o, 32'hA5000001);
        next_cycle(); #1;
        chk("bp_drain2_valid", r_valid_o, 1);
        chk("bp_drain2_data", r_rdata_o, 32'hA5000002);
        next_cycle(); #1;
        chk("bp_drained", r_valid_o, 0);

        // Reset with one buffered response and one in flight
        r_ready_i = 1'b0;
        next_cycle(); drive(1'b1, 32'd32 << 4, 1'b1, 4'h0, 32'h0); #1;
        chk("mr_gnt0", gnt_o, 1);
        next_cycle(); drive(1'b1, 32'd33 << 4, 1'b1, 4'h0, 32'h0); #1;
        chk("mr_gnt1", gnt_o, 1);
        next_cycle(); drive(1'b1, 32'd34 << 4, 1'b1, 4'h0, 32'h0); #1;
        chk("mr_pre_valid", r_valid_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("mr_gnt", gnt_o, 0);
        chk("mr_valid", r_valid_o, 0);
        chk("mr_rdata", r_rdata_o, 0);
        chk("mr_init_done", init_done_o, 0);
        chk("mr_csn", mem_csn_o, 1);
        chk("mr_wen", mem_wen_o, 1);
        @(negedge clk);
        rst_ni = 1'b1;
        r_ready_i = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            next_cycle(); #1;
            chk("mr_no_stale", r_valid_o, 0);
        end
        next_cycle(); drive(1'b1, 32'd40 << 4, 1'b1, 4'h0, 32'h0); #1;
        chk("mr_after_gnt", gnt_o, 1);
        next_cycle(); drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h0); #1;
        chk("mr_after_lat", r_valid_o, 0);
        next_cycle(); #1;
        chk("mr_after_valid", r_valid_o, 1);
        chk("mr_after_data", r_rdata_o, 32'hA5000008);
        next_cycle(); #1;
        chk("mr_after_drained", r_valid_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
